// File: rtl/conv_stim_gen_pkg.sv
// Shared types, LFSR polynomial and beat-count helpers for the conv stimulus sequencer.
package conv_stim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KERNELS = 2'd1,
        PIXELS  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Reserved encoding falls back to ramp data.
    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int kb(input int nk, input int ks, input int d, input int nl);
        return nk * ks * ks * d / nl;
    endfunction

    function automatic int pb(input int r, input int c, input int d, input int nl);
        return r * c * d / nl;
    endfunction

endpackage

// File: rtl/conv_stim_gen_lfsr.sv
// Per-lane Galois LFSR: reloads SEED on load_i, steps once per adv_i; q_o is the current beat's value.
module stim_lfsr
    import conv_stim_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] q_o
);

    localparam logic [DATA_W-1:0] MASK = DATA_W'(LFSR_TAPS);

    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/conv_stim_gen.sv
// Streams NUM_KERNELS kernels then one input map over two valid/ready streams; valids come straight
// from the state register, data/last hold while valid & !ready, one beat per clock with ready high.
module conv_stim_gen
    import conv_stim_pkg::*;
#(
    parameter int                ROWS        = 20,
    parameter int                COLS        = 20,
    parameter int                DEPTH       = 8,
    parameter int                KERNEL_SIZE = 3,
    parameter int                NUM_KERNELS = 5,
    parameter int                NUM_LANES   = 4,
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] LFSR_SEED   = DATA_W'(16'hACE1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [1:0]                    mode_i,
    input  logic [DATA_W-1:0]             const_i,
    output logic                          kern_valid_o,
    input  logic                          kern_ready_i,
    output logic [NUM_LANES*DATA_W-1:0]   kern_data_o,
    output logic                          kern_last_o,
    output logic                          pix_valid_o,
    input  logic                          pix_ready_i,
    output logic [NUM_LANES*DATA_W-1:0]   pix_data_o,
    output logic                          pix_last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int KB    = kb(NUM_KERNELS, KERNEL_SIZE, DEPTH, NUM_LANES);
    localparam int PB    = pb(ROWS, COLS, DEPTH, NUM_LANES);
    localparam int KPK   = KERNEL_SIZE * KERNEL_SIZE * DEPTH / NUM_LANES;
    localparam int CNT_W = $clog2(((KB > PB) ? KB : PB) + 1);
    localparam int KC_W  = $clog2(KPK + 1);

    generate
        if (DEPTH % NUM_LANES != 0) begin : g_bad_depth
            $error("conv_stim_gen: DEPTH must be a multiple of NUM_LANES");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [KC_W-1:0]    kcnt_q, kcnt_d;
    mode_t              mode_q, mode_d;
    logic [DATA_W-1:0]  const_q, const_d;

    logic               kern_acc;
    logic               pix_acc;
    logic               start_ok;
    logic [NUM_LANES*DATA_W-1:0] stream_dat;

    assign kern_acc = (state_q == KERNELS) && kern_ready_i;
    assign pix_acc  = (state_q == PIXELS) && pix_ready_i;
    assign start_ok = (state_q == IDLE) && start_i && !abort_i;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        kcnt_d  = kcnt_q;
        mode_d  = mode_q;
        const_d = const_q;
        if (abort_i) begin
            state_d = IDLE;
            beat_d  = '0;
            kcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = KERNELS;
                        beat_d  = '0;
                        kcnt_d  = '0;
                        mode_d  = mode_t'(mode_i);
                        const_d = const_i;
                    end
                end
                KERNELS: begin
                    if (kern_ready_i) begin
                        if (beat_q == CNT_W'(KB - 1)) begin
                            state_d = PIXELS;
                            beat_d  = '0;
                            kcnt_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                            kcnt_d = (kcnt_q == KC_W'(KPK - 1)) ? '0 : kcnt_q + 1'b1;
                        end
                    end
                end
                PIXELS: begin
                    if (pix_ready_i) begin
                        if (beat_q == CNT_W'(PB - 1)) begin
                            state_d = DONE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            kcnt_q  <= '0;
            mode_q  <= MODE_RAMP;
            const_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            kcnt_q  <= kcnt_d;
            mode_q  <= mode_d;
            const_q <= const_d;
        end
    end

    // The LFSR sequence runs continuously across the kernel and pixel streams.
    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            logic [DATA_W-1:0] lfsr_dat;
            logic [DATA_W-1:0] ramp_dat;

            stim_lfsr #(
                .DATA_W (DATA_W),
                .SEED   (LFSR_SEED ^ DATA_W'(l))
            ) u_lfsr (
                .clk    (clk),
                .rst    (rst),
                .load_i (start_ok),
                .adv_i  ((kern_acc || pix_acc) && !abort_i),
                .q_o    (lfsr_dat)
            );

            assign ramp_dat = DATA_W'(32'(beat_q) * 32'(NUM_LANES) + 32'(l));
            assign stream_dat[l*DATA_W +: DATA_W] =
                (mode_q == MODE_LFSR)  ? lfsr_dat :
                (mode_q == MODE_CONST) ? const_q  : ramp_dat;
        end
    endgenerate

    assign kern_valid_o = (state_q == KERNELS);
    assign pix_valid_o  = (state_q == PIXELS);
    assign kern_data_o  = kern_valid_o ? stream_dat : '0;
    assign pix_data_o   = pix_valid_o ? stream_dat : '0;
    assign kern_last_o  = kern_valid_o && (kcnt_q == KC_W'(KPK - 1));
    assign pix_last_o   = pix_valid_o && (beat_q == CNT_W'(PB - 1));
    assign busy_o       = kern_valid_o || pix_valid_o;
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_conv_stim_gen.sv
// Scoreboard bench for conv_stim_gen: a run-level model queues every expected beat, a negedge monitor checks.
module tb_conv_stim_gen;

    localparam int NL  = 4;
    localparam int DW  = 16;
    localparam int KPK = 3 * 3 * 8 / NL;
    localparam int KB  = 5 * KPK;
    localparam int PB  = 20 * 20 * 8 / NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, abort_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] const_i;
    logic          kern_valid_o, kern_ready_i, kern_last_o;
    logic          pix_valid_o, pix_ready_i, pix_last_o;
    logic [NL*DW-1:0] kern_data_o, pix_data_o;
    logic          busy_o, done_o;

    always #5 clk = ~clk;

    conv_stim_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .mode_i       (mode_i),
        .const_i      (const_i),
        .kern_valid_o (kern_valid_o),
        .kern_ready_i (kern_ready_i),
        .kern_data_o  (kern_data_o),
        .kern_last_o  (kern_last_o),
        .pix_valid_o  (pix_valid_o),
        .pix_ready_i  (pix_ready_i),
        .pix_data_o   (pix_data_o),
        .pix_last_o   (pix_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    typedef struct packed {
        logic        kern;
        logic        last;
        logic [63:0] dat;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    kern_acc = 0;
    int    pix_acc  = 0;
    int    done_cnt = 0;
    bit    rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Whole-run reference: ramp indexes restart per stream, the LFSR keeps stepping across both.
    task automatic push_run(input int mode, input logic [15:0] cval);
        logic [15:0] lf[NL];
        beat_t       e;
        for (int l = 0; l < NL; l++) lf[l] = 16'hACE1 ^ 16'(l);
        for (int b = 0; b < KB + PB; b++) begin
            int sb;
            sb     = (b < KB) ? b : b - KB;
            e.kern = (b < KB);
            e.last = (b < KB) ? (((b + 1) % KPK) == 0) : (sb == PB - 1);
            e.dat  = '0;
            for (int l = 0; l < NL; l++) begin
                case (mode)
                    1:       e.dat[l*16 +: 16] = lf[l];
                    2:       e.dat[l*16 +: 16] = cval;
                    default: e.dat[l*16 +: 16] = 16'(sb * NL + l);
                endcase
                lf[l] = lfsr_next(lf[l]);
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor
    beat_t       mon_e;
    logic [63:0] mon_dat, held_dat;
    logic        mon_last, mon_acc, hold_vld, done_exp;
    logic [2:0]  held_ctl;

    initial begin
        hold_vld = 1'b0;
        done_exp = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
            done_exp = 1'b0;
        end else begin
            chk("done_pulse", 64'(done_o), 64'(done_exp));
            if (done_o) done_cnt++;
            done_exp = 1'b0;
            mon_dat  = kern_valid_o ? kern_data_o : pix_data_o;
            mon_last = kern_valid_o ? kern_last_o : pix_last_o;
            if (kern_valid_o || pix_valid_o)
                chk("one_stream_valid", 64'(kern_valid_o & pix_valid_o), 64'(0));
            if (hold_vld) begin
                chk("hold_ctl", 64'({kern_valid_o, pix_valid_o, mon_last}), 64'(held_ctl));
                chk("hold_data", mon_dat, held_dat);
            end
            mon_acc = ((kern_valid_o && kern_ready_i) || (pix_valid_o && pix_ready_i)) && !abort_i;
            if (mon_acc) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: unexpected beat %h at %0t", mon_dat, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_stream", 64'(kern_valid_o), 64'(mon_e.kern));
                    chk("beat_data", mon_dat, mon_e.dat);
                    chk("beat_last", 64'(mon_last), 64'(mon_e.last));
                    done_exp = !mon_e.kern && mon_e.last;
                end
                if (kern_valid_o) kern_acc++;
                else pix_acc++;
            end
            hold_vld = (kern_valid_o || pix_valid_o) && !mon_acc && !abort_i;
            held_ctl = {kern_valid_o, pix_valid_o, mon_last};
            held_dat = mon_dat;
        end
    end

    initial begin
        kern_ready_i = 1'b1;
        pix_ready_i  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            kern_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready_i  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulse_start(input int mode, input logic [15:0] cval);
        mode_i  = 2'(mode);
        const_i = cval;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        const_i = ~cval;
    endtask

    // Full run with a stray start mid-run and another during DONE, both of which must be ignored.
    task automatic do_run(input int mode, input logic [15:0] cval);
        int n;
        push_run(mode, cval);
        pulse_start(mode, cval);
        n = 0;
        while (!done_o && n < 8000) begin
            @(posedge clk);
            #1;
            n++;
            start_i = (n == 50);
            if (n == 50) mode_i = 2'd1;
        end
        chk("run_done_seen", 64'(done_o), 64'(1));
        if (done_o) begin
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("idle_after_done", 64'({busy_o, kern_valid_o, pix_valid_o}), 64'(0));
        end else begin
            start_i = 1'b0;
            abort_i = 1'b1;
            @(posedge clk);
            #1;
            abort_i = 1'b0;
        end
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, p0, k0, d0;
        rst     = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        mode_i  = 2'd0;
        const_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({kern_valid_o, kern_last_o, pix_valid_o, pix_last_o, busy_o, done_o}), 64'(0));
        chk("rst_kdata", kern_data_o, 64'(0));
        chk("rst_pdata", pix_data_o, 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        rdy_rand = 1'b0;
        do_run(0, 16'h0000);
        chk("run1_kern_total", 64'(kern_acc), 64'(KB));
        chk("run1_pix_total", 64'(pix_acc), 64'(PB));

        rdy_rand = 1'b1;
        do_run(3, 16'h0000);
        do_run(2, 16'h5A5A);

        rdy_rand = 1'b0;
        do_run(1, 16'h0000);
        do_run(1, 16'h0000);

        // Abort at pixel beat 400.
        push_run(0, 16'h0000);
        p0 = pix_acc;
        d0 = done_cnt;
        pulse_start(0, 16'h0000);
        n = 0;
        while (pix_acc - p0 < 400 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach_400", 64'(pix_acc - p0), 64'(400));
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        chk("abort_valids", 64'({kern_valid_o, pix_valid_o, busy_o}), 64'(0));
        chk("abort_pix_count", 64'(pix_acc - p0), 64'(400));
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));

        // Asynchronous reset in the middle of a kernel phase.
        push_run(0, 16'h0000);
        k0 = kern_acc;
        pulse_start(0, 16'h0000);
        n = 0;
        while (kern_acc - k0 < 30 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_busy", 64'(busy_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({kern_valid_o, kern_last_o, pix_valid_o, pix_last_o, busy_o, done_o}), 64'(0));
        chk("rst_mid_kdata", kern_data_o, 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'(0));

        rdy_rand = 1'b1;
        do_run(0, 16'h0000);
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
